// File: rtl/dma_burst_splitter.sv
// DMA burst splitter: pops {src, dst, len, last} descriptors from the DMA
// descriptor FIFO and cuts each one into bus bursts of at most MAX_BEATS beats
// that never cross a BOUNDARY-aligned address on either source or destination.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for enable and a non-empty FIFO; issues the pop strobe
// POP    | FIFO output register is updating after the pop
// LOAD   | descriptor checked for alignment and latched
// CALC   | size of the next burst computed into the req_* registers
// ISSUE  | request presented until the engine accepts it
module dma_burst_splitter #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned MAX_BEATS  = 16,
    parameter int unsigned BOUNDARY   = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable_i,
    input  logic        abort_i,
    input  logic        dma_fifo_empty_i,
    output logic        dma_fifo_read_o,
    input  logic [95:0] dma_fifo_desc_i,
    input  logic        dma_fifo_last_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_src_o,
    output logic [31:0] req_dst_o,
    output logic [8:0]  req_beats_o,
    output logic        req_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] burst_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_CALC  = 3'd3,
        S_ISSUE = 3'd4
    } state_e;

    // Size arithmetic is done on 33 bits so BOUNDARY - offset cannot overflow.
    localparam logic [32:0] DB33   = 33'(DATA_BYTES);
    localparam logic [32:0] BND33  = 33'(BOUNDARY);
    localparam logic [8:0]  MAXB9  = 9'(MAX_BEATS);

    state_e      state_q, state_d;
    logic [31:0] src_q, dst_q, rem_q;
    logic        last_q;
    logic [31:0] req_src_q, req_dst_q;
    logic [8:0]  req_beats_q;
    logic        req_last_q;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] burst_cnt_q;

    logic        fifo_read, do_load, do_calc, do_hs;
    logic [31:0] desc_src, desc_dst, desc_len;
    logic        desc_misaligned;
    logic [32:0] rem_beats, src_room, dst_room, calc_bytes;
    logic [8:0]  calc_beats;
    logic        calc_last;
    logic [31:0] burst_bytes, rem_after;

    assign desc_src = dma_fifo_desc_i[95:64];
    assign desc_dst = dma_fifo_desc_i[63:32];
    assign desc_len = dma_fifo_desc_i[31:0];

    assign desc_misaligned = ((desc_src % 32'(DATA_BYTES)) != 32'd0) ||
                             ((desc_dst % 32'(DATA_BYTES)) != 32'd0) ||
                             ((desc_len % 32'(DATA_BYTES)) != 32'd0);

    assign burst_bytes = 32'(req_beats_q) * 32'(DATA_BYTES);
    assign rem_after   = rem_q - burst_bytes;

    // Next burst size: smallest of remaining length, MAX_BEATS and room to either boundary.
    always_comb begin
        rem_beats  = {1'b0, rem_q} / DB33;
        src_room   = (BND33 - ({1'b0, src_q} % BND33)) / DB33;
        dst_room   = (BND33 - ({1'b0, dst_q} % BND33)) / DB33;
        calc_beats = MAXB9;
        if (rem_beats < {24'd0, calc_beats}) calc_beats = rem_beats[8:0];
        if (src_room  < {24'd0, calc_beats}) calc_beats = src_room[8:0];
        if (dst_room  < {24'd0, calc_beats}) calc_beats = dst_room[8:0];
        calc_bytes = {24'd0, calc_beats} * DB33;
        calc_last  = last_q && (calc_bytes == {1'b0, rem_q});
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control strobes; abort overrides every state.
    always_comb begin
        state_d   = state_q;
        fifo_read = 1'b0;
        do_load   = 1'b0;
        do_calc   = 1'b0;
        do_hs     = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i && !dma_fifo_empty_i) begin
                        fifo_read = 1'b1;
                        state_d   = S_POP;
                    end
                end
                S_POP: state_d = S_LOAD;
                S_LOAD: begin
                    if (desc_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (desc_len == 32'd0) begin
                        do_load = 1'b1;
                        done_d  = dma_fifo_last_i;
                        state_d = S_IDLE;
                    end else begin
                        do_load = 1'b1;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    do_calc = 1'b1;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (req_ready_i) begin
                        do_hs = 1'b1;
                        if (rem_after == 32'd0) begin
                            done_d  = last_q;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Descriptor progress, request registers, status pulses and burst counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            req_src_q   <= '0;
            req_dst_q   <= '0;
            req_beats_q <= '0;
            req_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (do_load) begin
                src_q  <= desc_src;
                dst_q  <= desc_dst;
                rem_q  <= desc_len;
                last_q <= dma_fifo_last_i;
            end else if (do_hs) begin
                src_q       <= src_q + burst_bytes;
                dst_q       <= dst_q + burst_bytes;
                rem_q       <= rem_after;
                burst_cnt_q <= burst_cnt_q + 16'd1;
            end else if (abort_i) begin
                rem_q <= '0;
            end
            if (do_calc) begin
                req_src_q   <= src_q;
                req_dst_q   <= dst_q;
                req_beats_q <= calc_beats;
                req_last_q  <= calc_last;
            end
        end
    end

    assign dma_fifo_read_o = fifo_read;
    assign req_valid_o     = (state_q == S_ISSUE);
    assign req_src_o       = req_src_q;
    assign req_dst_o       = req_dst_q;
    assign req_beats_o     = req_beats_q;
    assign req_last_o      = req_last_q;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign burst_cnt_o     = burst_cnt_q;

endmodule

// File: doc/dma_burst_splitter.md
Name: dma_burst_splitter

Overview:
- Downstream consumer of the DMA descriptor FIFO.
- Pops {SRC, DST, LEN, last} descriptors and splits each one into bus burst requests.
- A burst never exceeds MAX_BEATS and never crosses a 4 KB boundary on either the source or the destination address.
- Feeds the DMA read/write engine through a valid/ready request channel, and reports chain completion and errors to the CSR block.

Parameters:
- DATA_BYTES, 8: bus width in bytes. Power of 2. All addresses and lengths are multiples of it.
- MAX_BEATS, 16: maximum beats per burst, 1..256.
- BOUNDARY, 4096: address boundary bursts must not cross. Power of 2, and at least DATA_BYTES*MAX_BEATS.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enable_i  in  1  allow popping new descriptors
- abort_i  in  1  synchronous flush of the descriptor in flight
- dma_fifo_empty_i  in  1  FIFO empty
- dma_fifo_read_o  out  1  FIFO pop strobe
- dma_fifo_desc_i  in  96  {src[31:0], dst[31:0], len[31:0]}; valid one cycle after the pop
- dma_fifo_last_i  in  1  last descriptor of the chain; valid with desc
- req_valid_o  out  1  burst request valid
- req_ready_i  in  1  engine accepts the request
- req_src_o  out  32  burst source byte address
- req_dst_o  out  32  burst destination byte address
- req_beats_o  out  9  beats in this burst, 1..MAX_BEATS
- req_last_o  out  1  final burst of a descriptor that has last=1
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the final burst of a last descriptor is accepted
- err_o  out  1  one-cycle pulse on a misaligned descriptor
- burst_cnt_o  out  16  bursts accepted since reset; wraps at 16 bits

Behaviour:
- Reset values: all outputs 0; state IDLE; internal src, dst and rem registers 0.
- States: IDLE, POP, LOAD, CALC, ISSUE.
- IDLE:
  - If enable_i && !dma_fifo_empty_i: assert dma_fifo_read_o for exactly this cycle, then go to POP.
  - dma_fifo_read_o is never asserted in any other state.
- POP: one wait cycle while the FIFO output register updates.
- LOAD: latch desc and last into src, dst, rem, last_q.
  - If any of src, dst or len is not a multiple of DATA_BYTES: pulse err_o, discard the descriptor, go to IDLE, no done_o.
  - Else if len == 0: pulse done_o if last_q, then go to IDLE.
  - Otherwise go to CALC.
- CALC computes:
  - beats = min(rem/DATA_BYTES, MAX_BEATS, (BOUNDARY - src%BOUNDARY)/DATA_BYTES, (BOUNDARY - dst%BOUNDARY)/DATA_BYTES).
  - All arithmetic is 33-bit unsigned; no overflow.
  - Register the result into the req_* outputs.
  - req_last_o = last_q && (beats*DATA_BYTES == rem).
  - Go to ISSUE.
- ISSUE: req_valid_o=1. req_* stay stable until req_valid_o && req_ready_i. On that handshake:
  - src += beats*DATA_BYTES; dst += beats*DATA_BYTES; rem -= beats*DATA_BYTES (all mod 2^32); burst_cnt_o increments.
  - If rem becomes 0: pulse done_o when last_q, then go to IDLE.
  - Otherwise go to CALC.
- Minimum latency: pop to first req_valid_o is 3 cycles (POP, LOAD, CALC). Back-to-back bursts of one descriptor are spaced by one CALC cycle.
- Address wrap: src or dst crossing 0xFFFFFFFF wraps silently. The boundary rule already splits the burst at 0x0.
- abort_i has priority over everything in every state:
  - Next state IDLE; req_valid_o drops the next cycle even without a handshake; rem cleared; no done_o.
  - A pop already issued stays consumed; that descriptor is dropped.
- enable_i deasserting affects only IDLE. A descriptor already in flight completes.
- Asynchronous reset mid-burst returns to the reset values immediately; the request in flight is lost.

Test Plan:
- src=0x1000, dst=0x2000, len=0x100, last=1, ready held 1 → 2 bursts of 16 beats (src 0x1000, 0x1080); req_last_o only on the 2nd; done_o one cycle after the 2nd handshake; burst_cnt_o=2.
- src=0x0FF0, dst=0x5000, len=0x40 → bursts of 2 beats @0x0FF0 then 6 beats @0x1000; dst 0x5000 then 0x5010.
- Two descriptors (last=0 then last=1) queued; ready toggling 1/0 every cycle → req_* stable while stalled; exactly one done_o, after the 2nd descriptor's final burst.
- Descriptor with src=0x1004 → err_o pulse in LOAD; no req_valid_o; next queued descriptor processed normally.
- len=0, last=1 → no request; done_o 2 cycles after the pop.
- abort_i asserted in ISSUE with ready=0 → req_valid_o low next cycle; busy_o=0; no done_o; FIFO not popped again until enable_i && !empty.
